// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, icache request and IF/ID register
// Optional feature macro: FETCH_PERF_EN adds saturating fetch/stall/flush counters.
module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter logic [31:0] HALT_OP = 32'hFFFF_FFFF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        freeze,
   input  logic        flush,
   input  logic        redirect_en,
   input  logic [31:0] redirect_addr,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   output logic [31:0] pc,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_npc,
   output logic        ifid_valid,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush,
`endif
   output logic        fetch_halted
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_MISS   = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] npc_q, npc_d;
   logic        valid_q, valid_d;
   logic        fetch_ok;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   // Priority: redirect > flush > freeze > fetch/miss; a halted stage ignores ihit.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      npc_d    = npc_q;
      valid_d  = valid_q;
      fetch_ok = 1'b0;
      if (redirect_en) begin
         pc_d    = redirect_addr & ~32'h3;
         instr_d = 32'h0;
         npc_d   = 32'h0;
         valid_d = 1'b0;
         state_d = ST_RUN;
      end else if (flush) begin
         instr_d = 32'h0;
         npc_d   = 32'h0;
         valid_d = 1'b0;
         state_d = ST_RUN;
      end else if (freeze) begin
         state_d = state_q;
      end else if (state_q != ST_HALTED) begin
         if (ihit) begin
            fetch_ok = 1'b1;
            instr_d  = imemload;
            npc_d    = pc_plus4;
            valid_d  = 1'b1;
            if (imemload == HALT_OP) begin
               state_d = ST_HALTED;
            end else begin
               pc_d    = pc_plus4;
               state_d = ST_RUN;
            end
         end else begin
            instr_d = 32'h0;
            npc_d   = 32'h0;
            valid_d = 1'b0;
            state_d = ST_MISS;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_RUN;
         pc_q    <= PC_INIT;
         instr_q <= 32'h0;
         npc_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         npc_q   <= npc_d;
         valid_q <= valid_d;
      end
   end

   assign imemREN      = (state_q != ST_HALTED);
   assign imemaddr     = pc_q;
   assign pc           = pc_q;
   assign ifid_instr   = instr_q;
   assign ifid_npc     = npc_q;
   assign ifid_valid   = valid_q;
   assign fetch_halted = (state_q == ST_HALTED);

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, stall_q, flushcnt_q;
   logic        stall_ev, flush_ev;

   assign stall_ev = freeze | (~ihit & (state_q != ST_HALTED));
   assign flush_ev = flush | redirect_en;

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge CLK) begin
      if (RST) begin
         fetched_q  <= 32'h0;
         stall_q    <= 32'h0;
         flushcnt_q <= 32'h0;
      end else begin
         if (fetch_ok && fetched_q != 32'hFFFF_FFFF) fetched_q <= fetched_q + 32'd1;
         if (stall_ev && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
         if (flush_ev && flushcnt_q != 32'hFFFF_FFFF) flushcnt_q <= flushcnt_q + 32'd1;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_stall   = stall_q;
   assign perf_flush   = flushcnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic        CLK = 1'b0;
   logic        RST, freeze, flush, redirect_en, ihit;
   logic [31:0] redirect_addr, imemload;
   logic        imemREN, ifid_valid, fetch_halted;
   logic [31:0] imemaddr, pc, ifid_instr, ifid_npc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

   int n_vec = 0;
   int n_miscmp = 0;

   // Reference model: architectural view only (halted flag, PC, IF/ID contents).
   logic [31:0] m_pc, m_instr, m_npc;
   logic        m_valid, m_halt;
   logic [31:0] m_fet, m_stl, m_fls;

   always #5 CLK = ~CLK;

   fetch_stage dut (
      .CLK(CLK), .RST(RST), .freeze(freeze), .flush(flush),
      .redirect_en(redirect_en), .redirect_addr(redirect_addr),
      .ihit(ihit), .imemload(imemload), .imemREN(imemREN), .imemaddr(imemaddr),
      .pc(pc), .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid),
`ifdef FETCH_PERF_EN
      .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush),
`endif
      .fetch_halted(fetch_halted)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input bit ev);
      return (ev && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
   endfunction

   task automatic bubble();
      m_instr = 32'h0;
      m_npc   = 32'h0;
      m_valid = 1'b0;
   endtask

   // Apply one cycle of inputs, advance the model across the edge, then compare.
   task automatic cycle(input bit rst, input bit fr, input bit fl, input bit re,
                        input logic [31:0] ra, input bit hit, input logic [31:0] ld);
      bit was_halt;
      RST = rst; freeze = fr; flush = fl; redirect_en = re;
      redirect_addr = ra; ihit = hit; imemload = ld;
      @(posedge CLK);
      was_halt = m_halt;
      if (rst) begin
         m_pc = 32'h0; bubble(); m_halt = 1'b0;
         m_fet = 0; m_stl = 0; m_fls = 0;
      end else begin
         m_fet = sat_inc(m_fet, !re && !fl && !fr && !was_halt && hit);
         m_stl = sat_inc(m_stl, fr || (!hit && !was_halt));
         m_fls = sat_inc(m_fls, fl || re);
         if (re) begin
            m_pc = {ra[31:2], 2'b00}; bubble(); m_halt = 1'b0;
         end else if (fl) begin
            bubble(); m_halt = 1'b0;
         end else if (fr || was_halt) begin
            m_halt = was_halt;
         end else if (hit) begin
            m_instr = ld;
            m_npc   = m_pc + 32'd4;
            m_valid = 1'b1;
            if (ld == HALT) m_halt = 1'b1;
            else m_pc = m_pc + 32'd4;
         end else begin
            bubble();
         end
      end
      #1;
      check("pc", pc, m_pc);
      check("imemaddr", imemaddr, m_pc);
      check("ifid_instr", ifid_instr, m_instr);
      check("ifid_npc", ifid_npc, m_npc);
      check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
      check("fetch_halted", {31'b0, fetch_halted}, {31'b0, m_halt});
      check("imemREN", {31'b0, imemREN}, {31'b0, !m_halt});
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, m_fet);
      check("perf_stall", perf_stall, m_stl);
      check("perf_flush", perf_flush, m_fls);
`endif
   endtask

   localparam logic [31:0] ADDI = 32'h2001_0005;

   initial begin
      bit r, fr, fl, re, hit;
      logic [31:0] ra, ld;
      m_pc = 0; m_instr = 0; m_npc = 0; m_valid = 0; m_halt = 0;
      m_fet = 0; m_stl = 0; m_fls = 0;

      // Reset and straight-line fetch
      cycle(1, 0, 0, 0, 0, 0, 0);
      check("rst_pc", pc, 32'h0);
      check("rst_ren", {31'b0, imemREN}, 32'd1);
      cycle(0, 0, 0, 0, 0, 1, ADDI);
      check("t1_npc", ifid_npc, 32'h4);
      check("t1_valid", {31'b0, ifid_valid}, 32'd1);
      cycle(0, 0, 0, 0, 0, 1, ADDI);
      check("t1_pc8", pc, 32'h8);

      // Freeze holds PC and IF/ID
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, 0, 0, 1, 32'h1234_5678);
         check("t2_pc", pc, 32'h8);
         check("t2_instr", ifid_instr, ADDI);
      end
      cycle(0, 0, 0, 0, 0, 1, 32'h1234_5678);
      check("t2_resume", pc, 32'hC);

      // Redirect beats freeze and discards the fetch
      cycle(0, 1, 0, 1, 32'h0000_0103, 1, ADDI);
      check("t3_pc", pc, 32'h100);
      check("t3_valid", {31'b0, ifid_valid}, 32'd0);

      // HALT then flush resumes at the same PC
      cycle(0, 0, 0, 1, 32'h40, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, HALT);
      check("t4_halt", {31'b0, fetch_halted}, 32'd1);
      check("t4_pc", pc, 32'h40);
      cycle(0, 0, 0, 0, 0, 1, ADDI);
      check("t4_hold", ifid_instr, HALT);
      cycle(0, 0, 1, 0, 0, 0, 0);
      check("t4_ren", {31'b0, imemREN}, 32'd1);
      cycle(0, 0, 0, 0, 0, 1, ADDI);
      check("t4_refetch", ifid_npc, 32'h44);

      // PC wrap
      cycle(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, ADDI);
      check("t5_pc", pc, 32'h0);
      check("t5_npc", ifid_npc, 32'h0);

      // Counter scenario, then reset mid-miss
      cycle(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1, ADDI);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);
`ifdef FETCH_PERF_EN
      check("t6_fet", perf_fetched, 32'd5);
      check("t6_stl", perf_stall, 32'd3);
      check("t6_fls", perf_flush, 32'd1);
`endif
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      check("t6_rst_pc", pc, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r   = ($urandom_range(0, 199) == 0);
         re  = ($urandom_range(0, 19) == 0);
         fl  = ($urandom_range(0, 11) == 0);
         fr  = ($urandom_range(0, 5) == 0);
         hit = ($urandom_range(0, 9) < 7);
         ra  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         ld  = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
         cycle(r, fr, fl, re, ra, hit, ld);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
